// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with single-outstanding memory request and 2-entry buffer
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_stall_d,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_issue;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_addr;
    logic        r_discard;

    logic [31:0] r_fifo_pc    [0:1];
    logic [31:0] r_fifo_instr [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic [31:0] w_redir_pc;
    logic        w_valid;
    logic        w_pop;
    logic        w_resp;
    logic        w_push;
    logic        w_ack_taken;
    logic [1:0]  w_count_after_pop;

    // Low address bits of a redirect target are dropped: fetches are word-aligned.
    assign w_redir_pc        = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_valid           = (r_count != 2'd0);
    // A redirect flushes the buffer, so nothing is handed to decode in that cycle.
    assign w_pop             = w_valid & ~i_stall_d & ~i_redirect;
    // A response counts in WAIT_DATA, or in WAIT_ACK when ack and data coincide.
    assign w_resp            = i_mem_rvalid & ((r_state == S_WAIT_DATA) |
                                               ((r_state == S_WAIT_ACK) & i_mem_ack));
    assign w_push            = w_resp & ~r_discard & ~i_redirect;
    assign w_ack_taken       = (r_state == S_WAIT_ACK) & i_mem_ack;
    assign w_count_after_pop = r_count - {1'b0, w_pop};

    // Next-state logic; a request is issued from IDLE whenever buffer room is guaranteed.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_redirect || (w_count_after_pop <= 2'd1)) begin
                    w_next_state = S_WAIT_ACK;
                    w_issue      = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (i_mem_ack) begin
                    w_next_state = i_mem_rvalid ? S_IDLE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (i_mem_rvalid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fetch PC, latched request address and the drop-next-response flag.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_discard  <= 1'b0;
        end else begin
            if (i_redirect) begin
                r_fetch_pc <= w_redir_pc;
            end else if (w_ack_taken && !r_discard) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_issue) begin
                r_req_addr <= i_redirect ? w_redir_pc : r_fetch_pc;
            end
            if (w_resp) begin
                r_discard <= 1'b0;
            end else if (i_redirect && (r_state != S_IDLE)) begin
                r_discard <= 1'b1;
            end
        end
    end

    // Two-entry {pc, instr} buffer; a redirect empties it and overrides push/pop.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int k = 0; k < 2; k++) begin
                r_fifo_pc[k]    <= RESET_PC;
                r_fifo_instr[k] <= NOP_INSTR;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_req_addr;
                r_fifo_instr[r_wr_ptr] <= i_mem_rdata;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_mem_req  = (r_state == S_WAIT_ACK);
    assign o_mem_addr = r_req_addr;
    assign o_valid    = w_valid;
    assign o_instr    = w_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
    assign o_pc       = r_fifo_pc[r_rd_ptr];
    assign o_pc_plus4 = o_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_arst_n;
    logic        i_stall_d;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;

    always #5 i_clk = ~i_clk;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_stall_d     (i_stall_d),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] start_pc;
        int          ack_dly;
        int          data_dly;
        logic [7:0]  stall_mask;
        int          n_pop;
        logic [31:0] exp_last_pc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    int          ack_dly, data_dly, wait_cnt, dcnt, pops;
    bit          mem_en, const_data, stall_v, redir_v, stale_v, rv_now;
    bit          phase, req_seen, drop_pending;
    logic [31:0] redir_pc_v, exp_fetch_pc, cur_pc, req_addr0, last_pc;
    exp_t        exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return const_data ? 32'h0050_0093 : ((a ^ 32'h5A5A_0000) | 32'h3);
    endfunction

    // One clock: check outputs, drive inputs from the memory model, then advance past the edge.
    task automatic step();
        exp_t        e;
        bit          ack, rv;
        logic [31:0] rd;
        chk("valid", {31'b0, o_valid}, {31'b0, (exp_q.size() != 0)});
        i_stall_d     = stall_v;
        i_redirect    = redir_v;
        i_redirect_pc = redir_pc_v;
        if (o_valid && !stall_v && !redir_v && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc", o_pc, e.pc);
            chk("instr", o_instr, e.instr);
            chk("pc_plus4", o_pc_plus4, e.pc + 32'd4);
            pops++;
            last_pc = o_pc;
        end
        ack = 1'b0;
        rv  = 1'b0;
        rd  = '0;
        if (mem_en) begin
            if (!phase && o_mem_req) begin
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    req_addr0 = o_mem_addr;
                    wait_cnt  = 0;
                    if (!drop_pending) chk("req_addr", o_mem_addr, exp_fetch_pc);
                end else begin
                    chk("addr_stable", o_mem_addr, req_addr0);
                end
                if (wait_cnt >= ack_dly) begin
                    ack      = 1'b1;
                    req_seen = 1'b0;
                    if (!drop_pending) begin
                        cur_pc       = exp_fetch_pc;
                        exp_fetch_pc = exp_fetch_pc + 32'd4;
                    end
                    if (data_dly == 0) rv = 1'b1;
                    else begin
                        phase = 1'b1;
                        dcnt  = 1;
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (phase) begin
                if (dcnt >= data_dly) begin
                    rv    = 1'b1;
                    phase = 1'b0;
                end else begin
                    dcnt++;
                end
            end
        end
        if (rv) rd = data_of(cur_pc);
        if (stale_v) begin
            rv = 1'b1;
            rd = 32'hDEAD_BEEF;
        end
        i_mem_ack    = ack;
        i_mem_rvalid = rv;
        i_mem_rdata  = rd;
        rv_now       = rv && !stale_v;
        if (redir_v) begin
            exp_q.delete();
            drop_pending = !rv && (phase || o_mem_req);
            exp_fetch_pc = redir_pc_v & 32'hFFFF_FFFC;
        end else if (rv && !stale_v) begin
            if (drop_pending) drop_pending = 1'b0;
            else begin
                e.pc    = cur_pc;
                e.instr = rd;
                exp_q.push_back(e);
            end
        end
        redir_v = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_pops(input int n, input logic [7:0] mask, input string name);
        int c;
        c = 0;
        while (pops < n && c < 400) begin
            stall_v = mask[c % 8];
            step();
            c++;
        end
        stall_v = 1'b0;
        chk({name, "_count"}, pops, n);
    endtask

    task automatic wait_data_phase();
        int c;
        c = 0;
        while (!phase && c < 100) begin
            step();
            c++;
        end
        chk("reach_wait_data", {31'b0, phase}, 32'd1);
    endtask

    task automatic check_reset();
        chk("rst_req", {31'b0, o_mem_req}, 32'd0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_instr", o_instr, NOP);
        chk("rst_pc", o_pc, RST_PC);
        chk("rst_pc_plus4", o_pc_plus4, RST_PC + 32'd4);
    endtask

    task automatic model_reset();
        phase        = 1'b0;
        req_seen     = 1'b0;
        drop_pending = 1'b0;
        exp_q.delete();
        exp_fetch_pc = RST_PC;
        i_mem_ack    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_redirect   = 1'b0;
        i_stall_d    = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   c;
        vecs[0] = '{32'h0000_0200, 0, 0, 8'h00, 4, 32'h0000_020C};
        vecs[1] = '{32'h0000_1000, 3, 0, 8'h00, 3, 32'h0000_1008};
        vecs[2] = '{32'h0000_0037, 1, 2, 8'h5A, 5, 32'h0000_0044};
        vecs[3] = '{32'hFFFF_FFFC, 0, 1, 8'h0F, 2, 32'h0000_0000};
        vecs[4] = '{32'h0000_0080, 2, 3, 8'hAA, 3, 32'h0000_0088};

        i_arst_n = 1'b0; i_mem_rdata = '0; i_redirect_pc = '0;
        mem_en = 1'b1; const_data = 1'b0; stall_v = 1'b0; redir_v = 1'b0; stale_v = 1'b0;
        redir_pc_v = '0; ack_dly = 0; data_dly = 0; pops = 0; cur_pc = RST_PC; last_pc = '0;
        model_reset();
        #1;
        check_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("first_req", {31'b0, o_mem_req}, 32'd1);
        chk("first_addr", o_mem_addr, RST_PC);

        // zero-latency memory, constant instruction word
        const_data = 1'b1;
        step();
        c = 1;
        while (!rv_now && c < 10) begin
            step();
            c++;
        end
        chk("latency_valid", {31'b0, o_valid}, 32'd1);
        run_pops(3, 8'h00, "seq");
        chk("seq_last_pc", last_pc, 32'h0000_0008);
        const_data = 1'b0;

        // long decode stall: buffer fills, fetching stops, then drains exactly two
        stall_v = 1'b1;
        repeat (10) step();
        chk("stall_noreq", {31'b0, o_mem_req}, 32'd0);
        chk("stall_valid", {31'b0, o_valid}, 32'd1);
        mem_en  = 1'b0;
        stall_v = 1'b0;
        pops    = 0;
        repeat (6) step();
        chk("stall_buffered", pops, 2);
        mem_en = 1'b1;

        // table of redirect targets, memory latencies and stall patterns
        for (int v = 0; v < 5; v++) begin
            ack_dly    = vecs[v].ack_dly;
            data_dly   = vecs[v].data_dly;
            redir_v    = 1'b1;
            redir_pc_v = vecs[v].start_pc;
            stall_v    = 1'b0;
            step();
            pops = 0;
            run_pops(vecs[v].n_pop, vecs[v].stall_mask, "vec");
            chk("vec_last_pc", last_pc, vecs[v].exp_last_pc);
        end

        // redirect while waiting for data
        ack_dly  = 0;
        data_dly = 3;
        wait_data_phase();
        redir_v    = 1'b1;
        redir_pc_v = 32'h0000_0103;
        step();
        chk("redir_flush", {31'b0, o_valid}, 32'd0);
        c = 0;
        while (!o_mem_req && c < 20) begin
            step();
            c++;
        end
        chk("redir_addr", o_mem_addr, 32'h0000_0100);
        pops = 0;
        run_pops(2, 8'h00, "redir_run");
        chk("redir_last_pc", last_pc, 32'h0000_0104);

        // reset in the middle of a transaction, then a stale response
        wait_data_phase();
        i_arst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        mem_en   = 1'b0;
        stale_v  = 1'b1;
        i_arst_n = 1'b1;
        step();
        chk("stale_valid", {31'b0, o_valid}, 32'd0);
        chk("stale_req", {31'b0, o_mem_req}, 32'd1);
        chk("stale_addr", o_mem_addr, RST_PC);
        step();
        chk("stale_valid2", {31'b0, o_valid}, 32'd0);
        stale_v  = 1'b0;
        mem_en   = 1'b1;
        data_dly = 0;
        pops     = 0;
        run_pops(2, 8'h00, "post_reset");
        chk("post_reset_last_pc", last_pc, RST_PC + 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
